// File: rtl/tpu_acc_pkg.sv
// Shared widths, saturation limits and sign extension for the TPU accumulator path.
package tpu_acc_pkg;

  localparam int ACC_BW_DEF  = 32;
  localparam int PSUM_BW_DEF = 20;

  localparam logic signed [ACC_BW_DEF-1:0] sat_max = {1'b0, {(ACC_BW_DEF-1){1'b1}}};
  localparam logic signed [ACC_BW_DEF-1:0] sat_min = {1'b1, {(ACC_BW_DEF-1){1'b0}}};

  function automatic logic signed [ACC_BW_DEF-1:0] sext(input logic signed [PSUM_BW_DEF-1:0] v);
    return ACC_BW_DEF'(v);
  endfunction

endpackage

// File: rtl/acc_lane_adder.sv
// One accumulator lane: overwrite-or-add with signed overflow detection.
// Define ACC_SATURATE_EN to clamp overflowing lanes instead of wrapping.
module acc_lane_adder
  import tpu_acc_pkg::*;
#(
  parameter int PARTIAL_SUM_BW = PSUM_BW_DEF,
  parameter int ACC_BW         = ACC_BW_DEF
) (
  input  logic signed [ACC_BW-1:0]         stored,
  input  logic signed [PARTIAL_SUM_BW-1:0] psum,
  input  logic                             first,
  output logic signed [ACC_BW-1:0]         sum,
  output logic                             lane_ovf
);

  logic signed [ACC_BW-1:0] base;
  logic signed [ACC_BW-1:0] ext;
  logic signed [ACC_BW-1:0] raw;

  assign ext  = sext(psum);
  assign base = first ? '0 : stored;
  assign raw  = base + ext;

  // Overflow only possible when both operands share a sign the result lost.
  assign lane_ovf = (base[ACC_BW-1] == ext[ACC_BW-1]) && (raw[ACC_BW-1] != ext[ACC_BW-1]);

`ifdef ACC_SATURATE_EN
  assign sum = lane_ovf ? (ext[ACC_BW-1] ? sat_min : sat_max) : raw;
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/accumulator_buffer.sv
// Accumulates de-skewed partial-sum rows into an addressed accumulator memory and
// emits the full-precision row on the last K-tile. Saturation via ACC_SATURATE_EN.
module accumulator_buffer
  import tpu_acc_pkg::*;
#(
  parameter int PARTIAL_SUM_BW = PSUM_BW_DEF,
  parameter int MATRIX_SIZE    = 8,
  parameter int ACC_BW         = ACC_BW_DEF,
  parameter int ACC_DEPTH      = 16,
  parameter int ACC_ADDR_BW    = 4
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_first,
  input  logic                              in_last,
  input  logic [ACC_ADDR_BW-1:0]            in_addr,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ACC_ADDR_BW-1:0]            out_addr,
  output logic [ACC_BW*MATRIX_SIZE-1:0]     out_data,
  input  logic                              clr_ovf,
  output logic                              overflow
);

  localparam int IN_ROW_BW  = PARTIAL_SUM_BW * MATRIX_SIZE;
  localparam int OUT_ROW_BW = ACC_BW * MATRIX_SIZE;

  logic                   s1_valid;
  logic                   s1_first;
  logic                   s1_last;
  logic [ACC_ADDR_BW-1:0] s1_addr;
  logic [IN_ROW_BW-1:0]   s1_data;

  logic [OUT_ROW_BW-1:0]  mem [ACC_DEPTH];
  logic [OUT_ROW_BW-1:0]  stored_row;
  logic [OUT_ROW_BW-1:0]  sum_row;
  logic [MATRIX_SIZE-1:0] lane_ovf;

  logic stall;
  logic accept;
  logic advance;

  // A last row can only leave S1 if the output register is free or draining.
  assign stall    = s1_valid & s1_last & out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  assign advance  = s1_valid & ~stall;

  assign stored_row = mem[s1_addr];

  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    acc_lane_adder #(
      .PARTIAL_SUM_BW(PARTIAL_SUM_BW),
      .ACC_BW        (ACC_BW)
    ) u_lane (
      .stored  (stored_row[i*ACC_BW +: ACC_BW]),
      .psum    (s1_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]),
      .first   (s1_first),
      .sum     (sum_row[i*ACC_BW +: ACC_BW]),
      .lane_ovf(lane_ovf[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_addr   <= '0;
      s1_data   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      overflow  <= 1'b0;
      // NOTE: the memory is cleared on reset because a non-first row may target
      // any row right afterwards; it is a flop array, so every row is reset.
      for (int r = 0; r < ACC_DEPTH; r++) begin
        mem[r] <= '0;
      end
    end else begin
      if (!stall) begin
        s1_valid <= accept;
        if (accept) begin
          s1_first <= in_first;
          s1_last  <= in_last;
          s1_addr  <= in_addr;
          s1_data  <= in_data;
        end
      end

      // NOTE: non-blocking writes make the next S1 row read this edge's result
      // through the combinational memory read, so same-address rows chain safely.
      if (advance) begin
        mem[s1_addr] <= sum_row;
      end

      if (advance && s1_last) begin
        out_valid <= 1'b1;
        out_addr  <= s1_addr;
        out_data  <= sum_row;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A new overflow wins over a simultaneous clear.
      if (advance && |lane_ovf) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accumulator_buffer.sv
// Randomized and directed bench for accumulator_buffer against an arithmetic row model.
// Honors ACC_SATURATE_EN to pick the expected overflow behaviour.
module tb_accumulator_buffer;

  localparam int PSW   = 20;
  localparam int N     = 8;
  localparam int AW    = 32;
  localparam int DEPTH = 16;
  localparam int ABW   = 4;

  localparam longint ACC_MAX = 64'sd2147483647;
  localparam longint ACC_MIN = -64'sd2147483648;

`ifdef ACC_SATURATE_EN
  localparam logic [AW-1:0] OVF_RES = 32'h7FFFFFFF;
`else
  localparam logic [AW-1:0] OVF_RES = 32'h80000000;
`endif

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_first = 1'b0;
  logic             in_last = 1'b0;
  logic [ABW-1:0]   in_addr = '0;
  logic [PSW*N-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ABW-1:0]   out_addr;
  logic [AW*N-1:0]  out_data;
  logic             clr_ovf = 1'b0;
  logic             overflow;

  always #5 clk = ~clk;

  accumulator_buffer dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_first (in_first),
    .in_last  (in_last),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_data (out_data),
    .clr_ovf  (clr_ovf),
    .overflow (overflow)
  );

  typedef struct {
    int              addr;
    logic [AW*N-1:0] data;
  } exp_t;

  exp_t   exp_q[$];
  longint mem_m[DEPTH][N];
  bit     ovf_m;
  bit     row_ovf;
  bit     rand_ready = 1'b0;
  int     err_cnt = 0;
  int     chk_cnt = 0;

  task automatic check(input string tag, input logic [AW*N-1:0] got, input logic [AW*N-1:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PSW*N-1:0] fill(input int v);
    logic [PSW*N-1:0] r;
    for (int i = 0; i < N; i++) r[i*PSW +: PSW] = v[PSW-1:0];
    return r;
  endfunction

  function automatic logic [AW*N-1:0] fill32(input int v);
    logic [AW*N-1:0] r;
    for (int i = 0; i < N; i++) r[i*AW +: AW] = v;
    return r;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < DEPTH; r++)
      for (int i = 0; i < N; i++) mem_m[r][i] = 0;
    exp_q.delete();
    ovf_m = 1'b0;
  endfunction

  // Row semantics from the lane rules: overwrite or add, then wrap or clamp to 32 bits.
  function automatic void model_accept(input int addr, input bit first, input bit last,
                                       input logic [PSW*N-1:0] d);
    exp_t              e;
    logic signed [PSW-1:0] p;
    longint            v;
    longint            s;
    e.addr  = addr;
    e.data  = '0;
    row_ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      p = d[i*PSW +: PSW];
      v = p;
      s = (first ? 64'sd0 : mem_m[addr][i]) + v;
      if (s > ACC_MAX || s < ACC_MIN) begin
        row_ovf = 1'b1;
`ifdef ACC_SATURATE_EN
        s = (s > 0) ? ACC_MAX : ACC_MIN;
`else
        s = longint'(int'(s));
`endif
      end
      mem_m[addr][i] = s;
      e.data[i*AW +: AW] = s[AW-1:0];
    end
    ovf_m = ovf_m | row_ovf;
    if (last) exp_q.push_back(e);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic send(input int addr, input bit first, input bit last, input logic [PSW*N-1:0] d);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_addr  = addr[ABW-1:0];
    in_first = first;
    in_last  = last;
    in_data  = d;
    for (int t = 0; t < 1000 && !done; t++) begin
      if (rand_ready) out_ready = ($urandom_range(3) != 0);
      #1;
      if (in_ready) begin
        model_accept(addr, first, last, d);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) check("send_timeout", {255'd0, done}, 1);
    in_valid = 1'b0;
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    #1;
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {255'd0, out_valid}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_addr", {252'd0, out_addr}, mon_e.addr);
        check("out_data", out_data, mon_e.data);
      end
    end
  end

  initial begin
    logic [PSW*N-1:0] d;

    @(negedge clk);
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    model_clear();
    check("rst_out_valid", {255'd0, out_valid}, 0);
    check("rst_in_ready",  {255'd0, in_ready}, 1);
    check("rst_overflow",  {255'd0, overflow}, 0);
    check("rst_out_addr",  {252'd0, out_addr}, 0);
    check("rst_out_data",  out_data, 0);

    // Single tile with sign extension, one-cycle latency.
    out_ready = 1'b1;
    d = '0;
    d[0 +: PSW]   = 20'hFFFFB;
    d[7*PSW +: PSW] = 20'd524287;
    send(3, 1'b1, 1'b1, d);
    check("lat_s1_only", {255'd0, out_valid}, 0);
    idle(1);
    check("lat_out_valid", {255'd0, out_valid}, 1);
    check("single_addr",   {252'd0, out_addr}, 3);
    check("single_l0",     {224'd0, out_data[31:0]}, 32'hFFFFFFFB);
    check("single_l7",     {224'd0, out_data[255:224]}, 32'h0007FFFF);
    idle(2);

    // Three back-to-back tiles to one address.
    send(5, 1'b1, 1'b0, fill(100));
    send(5, 1'b0, 1'b0, fill(100));
    check("tile_mid_no_out", {255'd0, out_valid}, 0);
    send(5, 1'b0, 1'b1, fill(100));
    check("tile_pre_out", {255'd0, out_valid}, 0);
    idle(1);
    check("tile_out_valid", {255'd0, out_valid}, 1);
    check("tile_sum", out_data, fill32(300));
    idle(2);

    // Backpressure: second last row parks in S1.
    out_ready = 1'b0;
    send(1, 1'b1, 1'b1, fill(3));
    send(2, 1'b1, 1'b1, fill(4));
    check("bp_in_ready",  {255'd0, in_ready}, 0);
    check("bp_addr",      {252'd0, out_addr}, 1);
    check("bp_data",      out_data, fill32(3));
    idle(3);
    check("bp_hold_ready", {255'd0, in_ready}, 0);
    check("bp_hold_addr",  {252'd0, out_addr}, 1);
    check("bp_hold_data",  out_data, fill32(3));
    out_ready = 1'b1;
    idle(1);
    check("bp_rel_valid", {255'd0, out_valid}, 1);
    check("bp_rel_addr",  {252'd0, out_addr}, 2);
    check("bp_rel_data",  out_data, fill32(4));
    check("bp_rel_ready", {255'd0, in_ready}, 1);
    idle(2);

    // Interleaved addresses.
    send(0, 1'b1, 1'b0, fill(1));
    send(1, 1'b1, 1'b0, fill(2));
    send(0, 1'b0, 1'b1, fill(10));
    send(1, 1'b0, 1'b1, fill(20));
    check("il_addr0", {252'd0, out_addr}, 0);
    check("il_data0", out_data, fill32(11));
    idle(1);
    check("il_addr1", {252'd0, out_addr}, 1);
    check("il_data1", out_data, fill32(22));
    idle(2);

    // Random rows with random consumer backpressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) d[i*PSW +: PSW] = PSW'($urandom);
      send(int'($urandom_range(DEPTH-1)), ($urandom_range(3) == 0), ($urandom_range(1) == 1), d);
      if ($urandom_range(4) == 0) idle(1);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    idle(5);
    check("rand_drain", exp_q.size(), 0);
    check("rand_ovf", {255'd0, overflow}, {255'd0, ovf_m});

    // Overflow: preload lane0 of row 7 to the positive limit, then add one.
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    ovf_m = 1'b0;
    check("ovf_clr0", {255'd0, overflow}, 0);
    d = '0;
    d[0 +: PSW] = 20'h7FFFF;
    send(7, 1'b1, 1'b0, d);
    repeat (4095) send(7, 1'b0, 1'b0, d);
    d[0 +: PSW] = 20'd4095;
    send(7, 1'b0, 1'b0, d);
    idle(2);
    check("ovf_pre", {255'd0, overflow}, 0);
    d[0 +: PSW] = 20'd1;
    send(7, 1'b0, 1'b1, d);
    idle(1);
    check("ovf_set",    {255'd0, overflow}, 1);
    check("ovf_result", {224'd0, out_data[31:0]}, OVF_RES);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    ovf_m = 1'b0;
    check("ovf_cleared", {255'd0, overflow}, 0);

    // Clear coinciding with a new overflow keeps the flag set.
`ifdef ACC_SATURATE_EN
    d[0 +: PSW] = 20'd1;
`else
    d[0 +: PSW] = 20'hFFFFF;
`endif
    send(7, 1'b0, 1'b0, d);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    ovf_m = row_ovf;
    check("ovf_clr_race", {255'd0, overflow}, 1);
    idle(1);

    // Reset while stalled discards everything and clears memory.
    out_ready = 1'b0;
    send(4, 1'b1, 1'b1, fill(5));
    send(6, 1'b1, 1'b1, fill(6));
    idle(1);
    check("stall_before_rst", {255'd0, in_ready}, 0);
    rstn = 1'b0;
    idle(1);
    rstn = 1'b1;
    model_clear();
    check("rst2_out_valid", {255'd0, out_valid}, 0);
    check("rst2_in_ready",  {255'd0, in_ready}, 1);
    check("rst2_overflow",  {255'd0, overflow}, 0);
    out_ready = 1'b1;
    send(2, 1'b0, 1'b0, fill(7));
    send(2, 1'b0, 1'b1, fill(0));
    idle(1);
    check("rst2_valid", {255'd0, out_valid}, 1);
    check("rst2_addr",  {252'd0, out_addr}, 2);
    check("rst2_data",  out_data, fill32(7));
    idle(3);
    check("final_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
